oam_dma: RTL and testbench

OAM_DMA -- requirements
Module: oam_dma

---
 rtl/oam_dma.sv | 108 ++++++++++
 tb/tb_oam_dma.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma
// Description : $4014 sprite DMA. Halts the CPU and copies page P
//               ($PP00-$PPFF) to $2004 as 256 read/write pairs.
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic        i_cs_n,
    input  logic        i_rw,
    input  logic [7:0]  i_data,
    output logic        o_rdy,
    output logic        o_active,
    output logic [15:0] o_address,
    output logic        o_rw,
    output logic [7:0]  o_data,
    input  logic [7:0]  i_bus_data,
    output logic [7:0]  o_debug_count,
    output logic [2:0]  o_debug_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HALT  = 3'd1,
        S_ALIGN = 3'd2,
        S_READ  = 3'd3,
        S_WRITE = 3'd4
    } state_t;

    localparam logic [15:0] C_OAMDATA_ADDR = 16'h2004;
    localparam logic [7:0]  C_LAST_INDEX   = 8'hFF;

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_page;
    logic [7:0]  r_count;
    logic [7:0]  r_data;
    logic        r_parity;
    logic        w_trigger;

    assign w_trigger = (r_state == S_IDLE) && !i_cs_n && !i_rw;

    // r_parity is 1 during an odd cycle, so the cycle after it is even.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_trigger ? S_HALT : S_IDLE;
            S_HALT:  w_next = r_parity ? S_READ : S_ALIGN;
            S_ALIGN: w_next = S_READ;
            S_READ:  w_next = S_WRITE;
            S_WRITE: w_next = (r_count == C_LAST_INDEX) ? S_IDLE : S_READ;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state  <= S_IDLE;
            r_page   <= 8'h00;
            r_count  <= 8'h00;
            r_data   <= 8'h00;
            r_parity <= 1'b0;
        end else begin
            r_parity <= ~r_parity;
            r_state  <= w_next;
            if (w_trigger) begin
                r_page  <= i_data;
                r_count <= 8'h00;
            end
            if (r_state == S_READ) begin
                r_data <= i_bus_data;
            end
            // Index wraps back to 0 after the final write so IDLE shows 0.
            if (r_state == S_WRITE) begin
                r_count <= (r_count == C_LAST_INDEX) ? 8'h00 : r_count + 8'd1;
            end
        end
    end

    always_comb begin
        o_rdy     = 1'b0;
        o_active  = 1'b0;
        o_address = 16'h0000;
        o_rw      = 1'b1;
        o_data    = 8'h00;
        case (r_state)
            S_IDLE: o_rdy = 1'b1;
            S_READ: begin
                o_active  = 1'b1;
                o_address = {r_page, r_count};
            end
            S_WRITE: begin
                o_active  = 1'b1;
                o_address = C_OAMDATA_ADDR;
                o_rw      = 1'b0;
                o_data    = r_data;
            end
            default: ;
        endcase
    end

    assign o_debug_count = r_count;
    assign o_debug_state = r_state;

endmodule
`default_nettype wire

// File: tb/tb_oam_dma.sv
`default_nettype none
// ============================================================================
// Module      : tb_oam_dma
// Description : Directed self-checking bench for oam_dma.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_oam_dma;

    logic        clk = 1'b1;
    logic        rst_n;
    logic        cs_n;
    logic        rw;
    logic [7:0]  din;
    logic        o_rdy;
    logic        o_active;
    logic [15:0] o_address;
    logic        o_rw;
    logic [7:0]  o_data;
    logic [7:0]  bus_data;
    logic [7:0]  dbg_count;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    // Memory model: every location holds its low address byte XOR A5.
    assign bus_data = o_address[7:0] ^ 8'hA5;

    oam_dma dut (
        .i_clk         (clk),
        .i_reset_n     (rst_n),
        .i_cs_n        (cs_n),
        .i_rw          (rw),
        .i_data        (din),
        .o_rdy         (o_rdy),
        .o_active      (o_active),
        .o_address     (o_address),
        .o_rw          (o_rw),
        .o_data        (o_data),
        .i_bus_data    (bus_data),
        .o_debug_count (dbg_count),
        .o_debug_state (dbg_state)
    );

    // Independent cycle counter; cycle 0 is the first cycle after release.
    int tb_cyc;
    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 0;
        else        tb_cyc <= tb_cyc + 1;
    end

    int passed = 0;
    int total  = 0;

    int          n_rdylow, n_align, n_reads, n_writes;
    bit          addr_ok, data_ok, seq_ok, even_ok, bus_ok, zero_seen, timeout;
    logic [15:0] last_raddr;
    logic [7:0]  last_rbyte;
    logic [7:0]  last_wcount;
    logic [2:0]  end_state;
    logic [7:0]  end_count;

    task automatic do_trigger(input logic [7:0] page, input bit halt_odd);
        @(posedge clk);
        while ((tb_cyc % 2) != (halt_odd ? 0 : 1)) @(posedge clk);
        #1 cs_n = 1'b0; rw = 1'b0; din = page;
        @(negedge clk);
        #1 cs_n = 1'b1; rw = 1'b1; din = 8'h00;
    endtask

    task automatic collect(input logic [7:0] page, input int retrig_at);
        int k;
        k = 0;
        n_rdylow = 0; n_align = 0; n_reads = 0; n_writes = 0;
        addr_ok = 1; data_ok = 1; seq_ok = 1; even_ok = 1; bus_ok = 1;
        zero_seen = 0; timeout = 0;
        last_raddr = 16'h0; last_rbyte = 8'h0; last_wcount = 8'h0;
        forever begin
            @(posedge clk);
            if (o_rdy) break;
            k++;
            if (k > 600) begin
                timeout = 1;
                break;
            end
            case (dbg_state)
                3'd1, 3'd2: begin
                    if (dbg_state == 3'd2) n_align++;
                    if (o_address !== 16'h0 || o_rw !== 1'b1 || o_data !== 8'h0 || o_active !== 1'b0)
                        bus_ok = 0;
                end
                3'd3: begin
                    if (o_address !== {page, 8'(n_reads)}) addr_ok = 0;
                    if (tb_cyc % 2 != 0) even_ok = 0;
                    if (o_rw !== 1'b1 || o_data !== 8'h0 || o_active !== 1'b1) bus_ok = 0;
                    if (o_address == 16'h0000) zero_seen = 1;
                    last_raddr = o_address;
                    last_rbyte = o_address[7:0] ^ 8'hA5;
                    n_reads++;
                end
                3'd4: begin
                    if (o_address !== 16'h2004 || o_rw !== 1'b0 || o_active !== 1'b1) bus_ok = 0;
                    if (o_data !== last_rbyte) data_ok = 0;
                    if (o_data !== (8'(n_writes) ^ 8'hA5)) seq_ok = 0;
                    last_wcount = dbg_count;
                    n_writes++;
                end
                default: bus_ok = 0;
            endcase
            if (retrig_at > 0 && k == retrig_at) begin
                #1 cs_n = 1'b0; rw = 1'b0; din = 8'h55;
            end else if (retrig_at > 0 && k == retrig_at + 2) begin
                #1 cs_n = 1'b1; rw = 1'b1; din = 8'h00;
            end
        end
        n_rdylow  = k;
        end_state = dbg_state;
        end_count = dbg_count;
        cs_n = 1'b1; rw = 1'b1; din = 8'h00;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; cs_n = 1'b1; rw = 1'b1; din = 8'h00;
        #2;
        total++; if (o_rdy !== 1'b1) $display("FAIL reset_rdy: got %b want 1", o_rdy); else passed++;
        total++; if (o_active !== 1'b0) $display("FAIL reset_active: got %b want 0", o_active); else passed++;
        total++; if (o_address !== 16'h0) $display("FAIL reset_addr: got %h want 0000", o_address); else passed++;
        total++; if (o_rw !== 1'b1 || o_data !== 8'h0) $display("FAIL reset_rw_data: got %b/%h want 1/00", o_rw, o_data); else passed++;
        total++; if (dbg_state !== 3'd0 || dbg_count !== 8'h0) $display("FAIL reset_state: got %0d/%0d want 0/0", dbg_state, dbg_count); else passed++;
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        total++; if (dbg_state !== 3'd0 || o_rdy !== 1'b1) $display("FAIL idle_after_reset: got state %0d rdy %b want 0/1", dbg_state, o_rdy); else passed++;
    endtask

    task automatic test_even_aligned;
        do_trigger(8'h02, 1'b1);
        collect(8'h02, 0);
        total++; if (timeout) $display("FAIL even_timeout: got timeout want completion"); else passed++;
        total++; if (n_rdylow != 513) $display("FAIL even_rdy_low: got %0d want 513", n_rdylow); else passed++;
        total++; if (n_align != 0) $display("FAIL even_align: got %0d want 0", n_align); else passed++;
        total++; if (n_reads != 256 || n_writes != 256) $display("FAIL even_count: got %0d/%0d want 256/256", n_reads, n_writes); else passed++;
        total++; if (!addr_ok) $display("FAIL even_addr_seq: got out-of-order address want $0200-$02FF"); else passed++;
        total++; if (!data_ok) $display("FAIL even_data: got write byte differing from read want equal"); else passed++;
        total++; if (!bus_ok) $display("FAIL even_bus: got bad bus outputs want decoded values"); else passed++;
        total++; if (!even_ok) $display("FAIL even_read_parity: got read on odd cycle want even"); else passed++;
        total++; if (end_state !== 3'd0) $display("FAIL even_end_state: got %0d want 0", end_state); else passed++;
    endtask

    task automatic test_odd_aligned;
        do_trigger(8'h02, 1'b0);
        collect(8'h02, 0);
        total++; if (n_rdylow != 514) $display("FAIL odd_rdy_low: got %0d want 514", n_rdylow); else passed++;
        total++; if (n_align != 1) $display("FAIL odd_align: got %0d want 1", n_align); else passed++;
        total++; if (!even_ok) $display("FAIL odd_read_parity: got read on odd cycle want even"); else passed++;
        total++; if (n_reads != 256 || !addr_ok) $display("FAIL odd_reads: got %0d reads addr_ok %0d want 256/1", n_reads, addr_ok); else passed++;
    endtask

    task automatic test_data_path;
        do_trigger(8'h07, 1'b1);
        collect(8'h07, 0);
        total++; if (!seq_ok) $display("FAIL data_seq: got byte sequence mismatch want A5,A4..5A"); else passed++;
        total++; if (n_writes != 256) $display("FAIL data_writes: got %0d want 256", n_writes); else passed++;
        total++; if (last_wcount !== 8'hFF) $display("FAIL data_last_count: got %0d want 255", last_wcount); else passed++;
        total++; if (end_count !== 8'h00) $display("FAIL data_idle_count: got %0d want 0", end_count); else passed++;
    endtask

    task automatic test_retrigger_and_read;
        bit stayed_idle;
        do_trigger(8'h03, 1'b1);
        collect(8'h03, 10);
        total++; if (n_rdylow != 513 || n_reads != 256) $display("FAIL retrig_len: got %0d cycles %0d reads want 513/256", n_rdylow, n_reads); else passed++;
        total++; if (!addr_ok || !data_ok) $display("FAIL retrig_addr: got page change or data error want page 03 unchanged"); else passed++;
        stayed_idle = 1;
        #1 cs_n = 1'b0; rw = 1'b1; din = 8'h09;
        repeat (10) begin
            @(posedge clk);
            if (o_rdy !== 1'b1 || dbg_state !== 3'd0 || o_active !== 1'b0) stayed_idle = 0;
        end
        #1 cs_n = 1'b1; din = 8'h00;
        total++; if (!stayed_idle) $display("FAIL cpu_read: got transfer start want idle"); else passed++;
    endtask

    task automatic test_reset_mid;
        int  w;
        bit  quiet;
        do_trigger(8'h04, 1'b1);
        w = 0;
        while (dbg_count !== 8'd100 && w < 600) begin
            @(posedge clk);
            w++;
        end
        total++; if (dbg_count !== 8'd100) $display("FAIL mid_reach100: got %0d want 100", dbg_count); else passed++;
        #1 rst_n = 1'b0;
        #1;
        total++; if (o_rdy !== 1'b1 || o_active !== 1'b0 || o_rw !== 1'b1) $display("FAIL mid_abort: got rdy %b active %b rw %b want 1/0/1", o_rdy, o_active, o_rw); else passed++;
        total++; if (dbg_state !== 3'd0 || o_address !== 16'h0) $display("FAIL mid_abort_state: got %0d/%h want 0/0000", dbg_state, o_address); else passed++;
        @(posedge clk); @(posedge clk);
        #1 rst_n = 1'b1;
        quiet = 1;
        repeat (20) begin
            @(posedge clk);
            if (o_rw !== 1'b1 || o_rdy !== 1'b1) quiet = 0;
        end
        total++; if (!quiet) $display("FAIL mid_quiet: got bus activity after reset want none"); else passed++;
        do_trigger(8'h04, 1'b1);
        collect(8'h04, 0);
        total++; if (n_writes != 256 || n_rdylow != 513 || !addr_ok) $display("FAIL mid_restart: got %0d writes %0d cycles want 256/513", n_writes, n_rdylow); else passed++;
    endtask

    task automatic test_page_wrap;
        do_trigger(8'hFF, 1'b0);
        collect(8'hFF, 0);
        total++; if (!addr_ok || n_reads != 256) $display("FAIL wrap_addr: got %0d reads addr_ok %0d want 256/1", n_reads, addr_ok); else passed++;
        total++; if (last_raddr !== 16'hFFFF) $display("FAIL wrap_last: got %h want FFFF", last_raddr); else passed++;
        total++; if (zero_seen) $display("FAIL wrap_zero: got access to 0000 want none"); else passed++;
    endtask

    initial begin
        test_reset();
        test_even_aligned();
        test_odd_aligned();
        test_data_path();
        test_retrigger_and_read();
        test_reset_mid();
        test_page_wrap();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
